// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode/state enums and default datapath width for alu_arbiter
package alu_pkg;
  localparam int W_DEF = 8;
  typedef enum logic [1:0] {ADD = 2'b00, LSH = 2'b01, AND = 2'b10, XOR = 2'b11} aluop_t;
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: combinational ALU with carry, zero and parity flags
module alu_arbiter_alu
  import alu_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         zero,
  output logic         par,
  output logic         co
);
  assign {co, y} = op == ADD ? {1'b0, a} + {1'b0, b} :
                   op == LSH ? {a, 1'b0} :
                   op == AND ? {1'b0, a & b} : {1'b0, a ^ b};
  assign zero = y == '0;
  assign par = ^y;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end sharing one registered ALU
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Req0,
  input  logic         Req1,
  input  logic [1:0]   Op0,
  input  logic [1:0]   Op1,
  input  logic [W-1:0] A0,
  input  logic [W-1:0] B0,
  input  logic [W-1:0] A1,
  input  logic [W-1:0] B1,
  input  logic         Ack,
  output logic         Gnt0,
  output logic         Gnt1,
  output logic         Valid,
  output logic         RsltId,
  output logic [W-1:0] Rslt,
  output logic         Zero,
  output logic         Par,
  output logic         SCo
);
  state_t state, state_nx;
  logic last, arb, cap, win;
  logic [1:0] op_q;
  logic [W-1:0] a_q, b_q, y;
  logic z, p, c;
  always_comb begin
    arb = state == IDLE || (state == HOLD && Ack);
    cap = arb && (Req0 || Req1);
    win = Req0 && Req1 ? ~last : Req1;
    state_nx = cap ? EXEC : state == EXEC ? HOLD : arb ? IDLE : state;
  end
  always_ff @(posedge Clk) state <= Reset ? IDLE : state_nx;
  // last doubles as the owner of the operation in flight
  always_ff @(posedge Clk) begin
    if (Reset) begin
      last <= 1'b1;
      {Gnt0, Gnt1, Valid, RsltId, Zero, Par, SCo} <= '0;
      Rslt <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      Gnt0 <= cap && !win;
      Gnt1 <= cap && win;
      if (cap) begin
        last <= win;
        op_q <= win ? Op1 : Op0;
        a_q <= win ? A1 : A0;
        b_q <= win ? B1 : B0;
      end
      if (state == EXEC) begin
        Valid <= 1'b1;
        RsltId <= last;
        Rslt <= y;
        Zero <= z;
        Par <= p;
        SCo <= c;
      end else if (state == HOLD && Ack) Valid <= 1'b0;
    end
  end
  alu_arbiter_alu #(.W(W)) u_alu (
    .op(op_q), .a(a_q), .b(b_q), .y(y), .zero(z), .par(p), .co(c)
  );
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus randomized transactions against a transaction-level model
module tb_alu_arbiter;
  logic Clk = 0, Reset, Req0, Req1, Ack;
  logic [1:0] Op0, Op1;
  logic [7:0] A0, B0, A1, B1;
  logic Gnt0, Gnt1, Valid, RsltId, Zero, Par, SCo;
  logic [7:0] Rslt;
  int nvec = 0, nerr = 0;
  logic p[2];
  logic [1:0] pop[2];
  logic [7:0] pa[2], pb[2];
  logic last, in_hold;
  logic [10:0] exp_r;
  logic exp_id;

  alu_arbiter #(.W(8)) dut (
    .Clk(Clk), .Reset(Reset), .Req0(Req0), .Req1(Req1), .Op0(Op0), .Op1(Op1),
    .A0(A0), .B0(B0), .A1(A1), .B1(B1), .Ack(Ack), .Gnt0(Gnt0), .Gnt1(Gnt1),
    .Valid(Valid), .RsltId(RsltId), .Rslt(Rslt), .Zero(Zero), .Par(Par), .SCo(SCo)
  );

  always #5 Clk = ~Clk;

  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [10:0] ref_alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int s;
    logic [7:0] r;
    s = op == 0 ? int'(a) + int'(b) : op == 1 ? int'(a) * 2 : op == 2 ? int'(a & b) : int'(a ^ b);
    r = 8'(s % 256);
    return {s >= 256, r == 0, ($countones(r) % 2) == 1, r};
  endfunction

  task drive();
    Req0 = p[0]; Op0 = pop[0]; A0 = pa[0]; B0 = pb[0];
    Req1 = p[1]; Op1 = pop[1]; A1 = pa[1]; B1 = pb[1];
  endtask

  task set_req(input int id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    p[id] = 1; pop[id] = op; pa[id] = a; pb[id] = b;
    drive();
  endtask

  task chk_result(input string tag);
    check({tag, "_gnt"}, {Gnt0, Gnt1}, 0);
    check({tag, "_valid"}, Valid, 1);
    check({tag, "_id"}, RsltId, exp_id);
    check({tag, "_flags_rslt"}, {SCo, Zero, Par, Rslt}, exp_r);
  endtask

  // one arbitration point: grant must appear the cycle after, result the cycle after that
  task arb_step(input logic ack);
    int w;
    Ack = ack;
    @(posedge Clk);
    @(negedge Clk);
    Ack = 0;
    w = (p[0] && p[1]) ? int'(!last) : int'(p[1]);
    check("gnt0", Gnt0, w == 0);
    check("gnt1", Gnt1, w == 1);
    check("valid_low_in_gnt", Valid, 0);
    exp_r = ref_alu(pop[w], pa[w], pb[w]);
    exp_id = w[0];
    last = w[0];
    p[w] = 0;
    drive();
    @(negedge Clk);
    chk_result("res");
    in_hold = 1;
  endtask

  task hold(input int k);
    repeat (k) begin
      @(negedge Clk);
      chk_result("hold");
    end
  endtask

  task go_idle();
    Ack = 1;
    @(posedge Clk);
    @(negedge Clk);
    Ack = 0;
    check("idle_valid", Valid, 0);
    check("idle_gnt", {Gnt0, Gnt1}, 0);
    Ack = 1'($urandom_range(0, 1));
    @(negedge Clk);
    Ack = 0;
    check("idle_ack_ignored", {Valid, Gnt0, Gnt1}, 0);
    in_hold = 0;
  endtask

  task do_reset();
    Reset = 1;
    p[0] = 0; p[1] = 0;
    drive();
    @(posedge Clk);
    @(negedge Clk);
    Reset = 0;
    last = 1;
    in_hold = 0;
    check("rst_outs", {Gnt0, Gnt1, Valid, RsltId, Zero, Par, SCo}, 0);
    check("rst_rslt", Rslt, 0);
  endtask

  initial begin
    Ack = 0;
    for (int i = 0; i < 2; i++) begin p[i] = 0; pop[i] = 0; pa[i] = 0; pb[i] = 0; end
    drive();
    @(negedge Clk);
    do_reset();
    set_req(0, 2'b00, 8'hF0, 8'h20);
    arb_step(0);
    check("r027", {SCo, Zero, Par, RsltId, Rslt}, {4'b1010, 8'h10});
    go_idle();
    do_reset();
    set_req(0, 2'b00, 8'h01, 8'h02);
    set_req(1, 2'b11, 8'h5A, 8'h5A);
    arb_step(0);
    check("r028_first", RsltId, 0);
    arb_step(1);
    check("r028", {SCo, Zero, Par, RsltId, Rslt}, {4'b0101, 8'h00});
    go_idle();
    set_req(1, 2'b01, 8'h81, 8'h00);
    arb_step(0);
    check("r029", {SCo, Zero, Par, Rslt}, {3'b101, 8'h02});
    set_req(0, 2'b10, 8'hCC, 8'h33);
    hold(5);
    arb_step(1);
    check("r030", {Zero, Rslt}, {1'b1, 8'h00});
    go_idle();
    set_req(1, 2'b00, 8'h11, 8'h22);
    @(posedge Clk);
    @(negedge Clk);
    check("r031_gnt", Gnt1, 1);
    Reset = 1;
    p[1] = 0;
    drive();
    @(posedge Clk);
    @(negedge Clk);
    Reset = 0;
    last = 1;
    check("r031_valid", {Valid, Gnt0, Gnt1}, 0);
    repeat (2) begin
      @(negedge Clk);
      check("r031_dropped", Valid, 0);
    end
    set_req(0, 2'b00, 8'h03, 8'h04);
    set_req(1, 2'b00, 8'h05, 8'h06);
    arb_step(0);
    check("r031_tie", RsltId, 0);
    for (int i = 0; i < 150; i++) begin
      if (!p[0] && !p[1] && $urandom_range(0, 4) == 0) go_idle();
      for (int id = 0; id < 2; id++)
        if (!p[id] && $urandom_range(0, 1) == 1)
          set_req(id, 2'($urandom), 8'($urandom), 8'($urandom));
      if (!p[0] && !p[1])
        set_req(int'($urandom_range(0, 1)), 2'($urandom), 8'($urandom), 8'($urandom));
      arb_step(in_hold ? 1'b1 : 1'($urandom_range(0, 1)));
      hold(int'($urandom_range(0, 3)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
